// File: rtl/filt_stream_pkg.sv
// Shared constants and the controller state encoding for filter_stream_host.
package filt_stream_pkg;

  localparam int FS_SAMPLE_W    = 32;
  localparam int FS_IN_DEPTH    = 16;
  localparam int FS_OUT_DEPTH   = 16;
  localparam int FS_COEF_CYCLES = 25;
  localparam int FS_DRAIN_LEN   = 6;
  localparam int FS_WARMUP      = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COEF  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with first-word-fall-through head, occupancy count and
// full/empty flags. A write while full is accepted only alongside a read.
module sample_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy update; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the FIFO at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/filter_stream_host.sv
// Streams samples into a coefficient-loaded filter and captures its outputs.
// Optional macro FILTER_WARMUP_DROP_EN discards the first WARMUP filter
// outputs after coefficient load; undefined, every output is captured.
module filter_stream_host
  import filt_stream_pkg::*;
#(
  parameter int SAMPLE_W    = FS_SAMPLE_W,
  parameter int IN_DEPTH    = FS_IN_DEPTH,
  parameter int OUT_DEPTH   = FS_OUT_DEPTH,
  parameter int COEF_CYCLES = FS_COEF_CYCLES,
  parameter int DRAIN_LEN   = FS_DRAIN_LEN,
  parameter int WARMUP      = FS_WARMUP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                clk_enable,
  output logic                start_coe,
  input  logic                start_togivedata,
  output logic [SAMPLE_W-1:0] data_in,
  input  logic                start_toread,
  input  logic [SAMPLE_W-1:0] data_out,
  output logic                hold,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic                underrun,
  output logic                overrun
);

  localparam int IN_CW   = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW  = $clog2(OUT_DEPTH) + 1;
  localparam int COEF_W  = $clog2(COEF_CYCLES + 1);
  localparam int DRAIN_W = $clog2(DRAIN_LEN + 1);

  state_t               state_q, state_d;
  logic [COEF_W-1:0]    coef_cnt_q, coef_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [SAMPLE_W-1:0]  data_in_q, data_in_d;
  logic                 underrun_q, underrun_d;
  logic                 overrun_q, overrun_d;
  logic                 last_seen_q, last_seen_d;

  logic [SAMPLE_W:0]    in_head;
  logic                 in_full, in_empty, in_push, in_pop;
  logic [IN_CW-1:0]     in_count;
  logic [SAMPLE_W-1:0]  out_head;
  logic                 out_full, out_empty, out_push, out_pop;
  logic [OUT_CW-1:0]    out_count;
  logic                 capture, keep, warm_discard;

  assign in_ready   = (in_count != IN_CW'(IN_DEPTH));
  assign in_push    = in_valid && !in_full;
  assign capture    = start_toread && (state_q == RUN || state_q == DRAIN || state_q == DONE);
  assign keep       = capture && !warm_discard;
  assign out_pop    = !out_empty && out_ready;
  assign out_push   = keep && (!out_full || out_pop);
  assign hold       = (out_count >= OUT_CW'(OUT_DEPTH - 1));
  assign out_valid  = !out_empty;
  assign out_data   = out_head;
  assign busy       = (state_q != IDLE);
  assign clk_enable = (state_q != IDLE);
  assign start_coe  = (state_q == COEF);
  assign data_in    = data_in_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

  // Input FIFO: the extra top bit carries the in_last tag.
  sample_fifo #(.WIDTH(SAMPLE_W + 1), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset),
    .wr_en(in_push), .wr_data({in_last, in_data}),
    .rd_en(in_pop), .rd_data(in_head),
    .full(in_full), .empty(in_empty), .count(in_count)
  );

  // Output FIFO holding captured filter results.
  sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset),
    .wr_en(out_push), .wr_data(data_out),
    .rd_en(out_pop), .rd_data(out_head),
    .full(out_full), .empty(out_empty), .count(out_count)
  );

`ifdef FILTER_WARMUP_DROP_EN
  localparam int WARM_W = $clog2(WARMUP + 2);
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              exit_coef;

  assign exit_coef    = (state_q == COEF) && (state_d == RUN);
  assign warm_discard = (warm_cnt_q < WARM_W'(WARMUP));

  // Count filter outputs since coefficient load, saturating at WARMUP.
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (exit_coef) warm_cnt_d = '0;
    else if (capture && warm_discard) warm_cnt_d = warm_cnt_q + 1'b1;
  end

  // Warm-up counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) warm_cnt_q <= '0;
    else       warm_cnt_q <= warm_cnt_d;
  end
`else
  assign warm_discard = 1'b0;
`endif

  // Controller next-state, input feed to the filter and sticky flags.
  always_comb begin
    state_d     = state_q;
    coef_cnt_d  = coef_cnt_q;
    drain_cnt_d = drain_cnt_q;
    data_in_d   = data_in_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    last_seen_d = last_seen_q;
    in_pop      = 1'b0;

    if (keep && out_full && !out_pop) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = COEF;
          coef_cnt_d = '0;
          underrun_d = 1'b0;
          overrun_d  = 1'b0;
        end
      end
      COEF: begin
        if (coef_cnt_q == COEF_W'(COEF_CYCLES - 1)) state_d = RUN;
        else coef_cnt_d = coef_cnt_q + 1'b1;
      end
      RUN: begin
        if (start_togivedata) begin
          if (!in_empty) begin
            in_pop    = 1'b1;
            data_in_d = in_head[SAMPLE_W-1:0];
            if (in_head[SAMPLE_W] && last_seen_q) begin
              last_seen_d = 1'b0;
              state_d     = DRAIN;
              drain_cnt_d = '0;
            end
          end else begin
            data_in_d  = '0;
            underrun_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (start_togivedata) begin
          data_in_d = '0;
          if (drain_cnt_q == DRAIN_W'(DRAIN_LEN - 1)) state_d = DONE;
          else drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A newly pushed last tag wins over clearing an older one.
    if (in_push && in_last) last_seen_d = 1'b1;
  end

  // Controller registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      coef_cnt_q  <= '0;
      drain_cnt_q <= '0;
      data_in_q   <= '0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      coef_cnt_q  <= coef_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      data_in_q   <= data_in_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      last_seen_q <= last_seen_d;
    end
  end

endmodule

// File: tb/tb_filter_stream_host.sv
// Directed bench for filter_stream_host; builds with or without
// FILTER_WARMUP_DROP_EN and adjusts expected captures accordingly.
module tb_filter_stream_host;

  localparam int SW = 32;
`ifdef FILTER_WARMUP_DROP_EN
  localparam int SKIP = 7;
`else
  localparam int SKIP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, go, in_valid, in_last, start_togivedata, start_toread, out_ready;
  logic [SW-1:0] in_data, data_out;
  logic          in_ready, clk_enable, start_coe, hold, out_valid, busy, underrun, overrun;
  logic [SW-1:0] data_in, out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_stream_host dut (
    .clk(clk), .reset(reset), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .clk_enable(clk_enable), .start_coe(start_coe),
    .start_togivedata(start_togivedata), .data_in(data_in),
    .start_toread(start_toread), .data_out(data_out), .hold(hold),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .underrun(underrun), .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1; tick(); go = 1'b0;
  endtask

  task automatic push_in(input logic [SW-1:0] v, input logic last);
    in_valid = 1'b1; in_data = v; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic request(output logic [SW-1:0] v);
    start_togivedata = 1'b1; tick(); start_togivedata = 1'b0;
    v = data_in;
  endtask

  task automatic capture(input logic [SW-1:0] v);
    start_toread = 1'b1; data_out = v; tick(); start_toread = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (start_coe && n < 60) begin tick(); n++; end
    checks++;
    if (start_coe !== 1'b0) begin
      errors++; $display("FAIL wait_run start_coe got %0b want 0", start_coe);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, clk_enable, start_coe, hold, out_valid, underrun, overrun, in_ready} !== 8'b0000_0001) begin
      errors++; $display("FAIL reset_flags got %b want 00000001",
        {busy, clk_enable, start_coe, hold, out_valid, underrun, overrun, in_ready});
    end
    checks++;
    if (data_in !== '0) begin errors++; $display("FAIL reset_data_in got %0h want 0", data_in); end
  endtask

  task automatic test_coef();
    int n = 0;
    pulse_go();
    while (start_coe && n < 60) begin n++; tick(); end
    checks++;
    if (n !== 25) begin errors++; $display("FAIL coef_cycles got %0d want 25", n); end
    checks++;
    if ({busy, clk_enable, start_coe} !== 3'b110) begin
      errors++; $display("FAIL run_entry got %b want 110", {busy, clk_enable, start_coe});
    end
    pulse_go();
    checks++;
    if ({busy, start_coe} !== 2'b10) begin
      errors++; $display("FAIL go_ignored got %b want 10", {busy, start_coe});
    end
  endtask

  task automatic test_stream();
    logic [SW-1:0] v, exp;
    logic [SW-1:0] exp_q[$];
    int j = 0;
    for (int k = 1; k <= 10; k++) push_in(k, k == 10);
    for (int i = 1; i <= 16; i++) begin
      exp = (i <= 10) ? i : 0;
      request(v);
      checks++;
      if (v !== exp) begin errors++; $display("FAIL stream_data_in[%0d] got %0h want %0h", i, v, exp); end
      capture(exp);
      if (i > SKIP) exp_q.push_back(exp);
    end
    checks++;
    if ({busy, underrun, overrun, out_valid, hold} !== {4'b1001, (16 - SKIP) >= 15}) begin
      errors++; $display("FAIL stream_done_flags got %b want %b",
        {busy, underrun, overrun, out_valid, hold}, {4'b1001, (16 - SKIP) >= 15});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && out_valid; c++) begin
      checks++;
      if (j >= exp_q.size() || out_data !== exp_q[j]) begin
        errors++; $display("FAIL stream_out[%0d] got %0h want %0h", j, out_data,
          (j < exp_q.size()) ? exp_q[j] : 32'hx);
      end
      j++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (j !== 16 - SKIP) begin errors++; $display("FAIL stream_out_count got %0d want %0d", j, 16 - SKIP); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_to_idle busy got %0b want 0", busy); end
  endtask

  task automatic test_warmup();
    int j = 0;
    pulse_go();
    wait_run();
    out_ready = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      if (c <= 20) begin start_toread = 1'b1; data_out = c; end
      tick();
      start_toread = 1'b0;
      if (out_valid) begin
        checks++;
        if (out_data !== SKIP + 1 + j) begin
          errors++; $display("FAIL warmup_out[%0d] got %0d want %0d", j, out_data, SKIP + 1 + j);
        end
        j++;
      end
    end
    out_ready = 1'b0;
    checks++;
    if (j !== 20 - SKIP) begin errors++; $display("FAIL warmup_count got %0d want %0d", j, 20 - SKIP); end
  endtask

  task automatic test_overflow();
    int j = 0;
    for (int k = 1; k <= 17; k++) begin
      capture(200 + k);
      if (k == 14) begin
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL hold_at_14 got %0b want 0", hold); end
      end
      if (k == 15) begin
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL hold_at_15 got %0b want 1", hold); end
      end
      if (k == 16) begin
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_at_16 got %0b want 0", overrun); end
      end
      if (k == 17) begin
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_at_17 got %0b want 1", overrun); end
      end
    end
    out_ready = 1'b1; start_toread = 1'b1; data_out = 999;
    checks++;
    if (out_data !== 201) begin errors++; $display("FAIL full_head got %0d want 201", out_data); end
    tick();
    start_toread = 1'b0; out_ready = 1'b0;
    checks++;
    if ({hold, out_valid, overrun} !== 3'b111) begin
      errors++; $display("FAIL full_push_pop got %b want 111", {hold, out_valid, overrun});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && out_valid; c++) begin
      checks++;
      if (out_data !== ((j < 15) ? 202 + j : 999)) begin
        errors++; $display("FAIL overflow_out[%0d] got %0d want %0d", j, out_data, (j < 15) ? 202 + j : 999);
      end
      j++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (j !== 16) begin errors++; $display("FAIL overflow_out_count got %0d want 16", j); end
  endtask

  task automatic test_underrun();
    logic [SW-1:0] v;
    push_in(32'h55, 1'b0);
    request(v);
    checks++;
    if ({v, underrun} !== {32'h55, 1'b0}) begin
      errors++; $display("FAIL pre_underrun got %0h/%0b want 55/0", v, underrun);
    end
    request(v);
    checks++;
    if ({v, underrun} !== {32'h0, 1'b1}) begin
      errors++; $display("FAIL underrun got %0h/%0b want 0/1", v, underrun);
    end
    push_in(32'h66, 1'b1);
    request(v);
    checks++;
    if (v !== 32'h66) begin errors++; $display("FAIL last_sample got %0h want 66", v); end
    for (int i = 0; i < 6; i++) begin
      request(v);
      checks++;
      if (v !== '0) begin errors++; $display("FAIL drain_zero[%0d] got %0h want 0", i, v); end
    end
    tick();
    checks++;
    if ({busy, underrun, overrun} !== 3'b011) begin
      errors++; $display("FAIL sticky_in_idle got %b want 011", {busy, underrun, overrun});
    end
    pulse_go();
    checks++;
    if ({underrun, overrun, start_coe} !== 3'b001) begin
      errors++; $display("FAIL sticky_clear_on_go got %b want 001", {underrun, overrun, start_coe});
    end
  endtask

  task automatic test_mid_reset();
    logic [SW-1:0] v;
    wait_run();
    for (int k = 1; k <= 6; k++) push_in(k, 1'b0);
    request(v);
    for (int k = 0; k < 8; k++) capture(300 + k);
    checks++;
    if ({v, out_valid, busy} !== {32'd1, 2'b11}) begin
      errors++; $display("FAIL pre_reset got %0h/%b want 1/11", v, {out_valid, busy});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, clk_enable, start_coe, hold, out_valid, underrun, overrun, in_ready} !== 8'b0000_0001) begin
      errors++; $display("FAIL mid_reset_flags got %b want 00000001",
        {busy, clk_enable, start_coe, hold, out_valid, underrun, overrun, in_ready});
    end
    checks++;
    if (data_in !== '0) begin errors++; $display("FAIL mid_reset_data_in got %0h want 0", data_in); end
    tick();
    reset = 1'b0;
    pulse_go();
    wait_run();
    request(v);
    checks++;
    if ({v, underrun} !== {32'h0, 1'b1}) begin
      errors++; $display("FAIL fifo_flushed got %0h/%0b want 0/1", v, underrun);
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    start_togivedata = 1'b0; start_toread = 1'b0; data_out = '0; out_ready = 1'b0;
    tick(); tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_coef();
    test_stream();
    test_warmup();
    test_overflow();
    test_underrun();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
